lsu_misalign_seq: RTL and testbench
===================================

# lsu_misalign_seq

Load/store sequencer between the single-cycle core's execute stage and `data_memory`. Aligned accesses pass straight through in the same cycle. Misaligned halfword and word accesses are split into consecutive byte accesses while the core is stalled, then reassembled. Every request is bounds- and funct3-checked before it reaches memory.

## Interface
Parameters:
- `MEM_BYTES`, 128: data memory size in bytes; valid addresses are 0..MEM_BYTES-1.
- `CNT_W`, 16: width of the misaligned-access counter.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: core presents a load/store this cycle.
- `req_write` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V load/store funct3.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data.
- `stall` out 1: core must hold PC and request stable.
- `rdata` out 32: load result, already extended.
- `fault` out 1: illegal funct3 or out-of-range access; no memory access performed.
- `misalign_count` out CNT_W: saturating count of completed split accesses.
- `MemRead`, `MemWrite` out 1: to data_memory.
- `mem_funct3` out 3: to data_memory.
- `mem_addr` out 32: to data_memory.
- `mem_write_data` out 32: to data_memory.
- `mem_read_data` in 32: from data_memory (combinational read).

## Operation
- Legal loads: 000, 001, 010, 100, 101. Legal stores: 000, 001, 010. Anything else sets `fault`.
- Size N = 1, 2 or 4 bytes. Out-of-range when `req_addr + N - 1 > MEM_BYTES-1`. Compute the sum in 33 bits so it cannot wrap. Out-of-range sets `fault`.
- On `fault`: MemRead=MemWrite=0, rdata=0, stall=0, for one cycle only.
- Aligned: byte always; halfword when addr[0]=0; word when addr[1:0]=0.
  - Memory ports carry the request unchanged.
  - `rdata` = `mem_read_data`, same cycle.
  - stall=0.
- Misaligned halfword or word: handled by a byte-sequencing FSM.
  - **IDLE**: misaligned legal request accepted.
    - Issue byte 0 this cycle: `mem_funct3`=000 (store) or 100 (load), `mem_addr`=req_addr.
    - stall=1.
    - Latch addr, wdata, funct3, N.
    - idx←1, go SPLIT.
  - **SPLIT**: issue byte idx at latched addr+idx, stall=1.
    - Store byte = wdata[8·idx +: 8].
    - Load byte mem_read_data[7:0] goes into assembly register byte idx at posedge.
    - Byte 0 is captured the same way in the IDLE issue cycle.
    - When idx = N-1: go DONE. Otherwise idx←idx+1.
  - **DONE**: no memory access, stall=0.
    - rdata = assembled value, sign-extended for 001 and zero-extended for 101. Stores give rdata=0.
    - misalign_count increments, saturating at all-ones.
    - Go IDLE.
- Request-stability rule: the request is ignored while in SPLIT/DONE; latched copies are used. The core re-presents the next instruction after DONE.
- `req_valid`=0 in IDLE: all memory controls 0, rdata 0, stall 0.

## Timing
- Aligned access: 0 added cycles.
- Misaligned access: N+1 cycles, stall high for the first N. Halfword = 3 cycles, word = 5 cycles.
- Stores commit one byte per posedge during the issue cycles.
- The last byte of a split store is written at the posedge entering DONE.
- Reset (asynchronous, any state):
  - state=IDLE, idx=0.
  - Assembly register 0, misalign_count 0.
  - stall/fault/rdata/mem controls 0 when req_valid=0.
- Reset mid-split aborts the access. Bytes already written stay written.
- stall, fault, rdata and memory controls are combinational from state and request. No output depends on mem_read_data in the same cycle except aligned rdata.

## Structure
- `lsu_pkg` holds:
  - funct3 constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW.
  - State enum: `lsu_state_t` {IDLE, SPLIT, DONE}.
  - Function `access_size(funct3)`.
- Sub-module `lsu_load_ext`: combinational 32-bit sign/zero extension from funct3. It is used for both the aligned path and the DONE path.

## Test plan
- Aligned lw, addr 0x10 holding DEADBEEF -> rdata=DEADBEEF in the same cycle, stall=0, MemRead=1 with funct3=010.
- Misaligned lw at 0x11, bytes 0x11..0x14 = 11,22,33,44 -> stall high for 4 cycles, mem_addr sequence 11,12,13,14 with funct3=100, then rdata=44332211 in cycle 5, misalign_count=1.
- Misaligned sh of 0x00001234 at 0x03 -> cycle 1 writes mem[3]=34, cycle 2 writes mem[4]=12, stall high for 2 cycles, DONE in cycle 3.
- Misaligned lh at 0x07, bytes 07=00, 08=80 -> rdata=FFFF8000. The same access with lhu -> 00008000.
- Out-of-range and illegal requests:
  - lw at 0x7E -> fault=1, MemRead=0, stall=0.
  - sb with funct3=100 -> fault=1, MemWrite=0.
- Async reset asserted in cycle 2 of a misaligned sw at 0x01 -> immediately state IDLE and stall=0. mem[1] holds the new byte, mem[2..4] are unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer.
//   - RISC-V load/store funct3 encodings
//   - lsu_state_t: sequencer FSM states
//   - access_size(): byte count (1, 2 or 4) of an access; 0 for encodings
//     that have no defined size
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        SPLIT,
        DONE
    } lsu_state_t;

    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   access_size = 3'd1;
            2'b01:   access_size = 3'd2;
            2'b10:   access_size = 3'd4;
            default: access_size = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load-result extension: sign- or zero-extends the low byte/halfword of
// data according to a load funct3. Words and any other encoding pass through.
//   funct3 in 3  : load funct3
//   data   in 32 : raw data, access bytes in the low lanes
//   ext    out 32: extended result
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] data,
    output logic [31:0] ext
);

    always_comb begin
        case (funct3)
            F3_LB:   ext = {{24{data[7]}}, data[7:0]};
            F3_LH:   ext = {{16{data[15]}}, data[15:0]};
            F3_LW:   ext = data;
            F3_LBU:  ext = {24'b0, data[7:0]};
            F3_LHU:  ext = {16'b0, data[15:0]};
            default: ext = data;
        endcase
    end

endmodule

// File: rtl/lsu_misalign_seq.sv
// Load/store sequencer between the execute stage and data memory.
// Aligned accesses pass through combinationally. Misaligned halfword/word
// accesses are split into byte accesses while the core is stalled, then
// the loaded bytes are reassembled and extended in a final DONE cycle.
//   clk, rst (async, active-high)
//   req_valid/req_write/req_funct3/req_addr/req_wdata : core request
//   stall, rdata, fault, misalign_count               : to core
//   MemRead/MemWrite/mem_funct3/mem_addr/mem_write_data: to data memory
//   mem_read_data                                     : from data memory
module lsu_misalign_seq
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 128,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_write,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             stall,
    output logic [31:0]      rdata,
    output logic             fault,
    output logic [CNT_W-1:0] misalign_count,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [2:0]       mem_funct3,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_write_data,
    input  logic [31:0]      mem_read_data
);

    lsu_state_t  state;
    logic [1:0]  idx;
    logic [1:0]  last_idx;
    logic [31:0] addr_lat;
    logic [31:0] wdata_lat;
    logic [2:0]  funct3_lat;
    logic        write_lat;
    logic [31:0] asm_data;

    // Request decode; only meaningful while IDLE. Memory is never touched
    // while reset is asserted, even if the core still drives a request.
    logic        active;
    logic [2:0]  req_size;
    logic        f3_legal;
    logic [32:0] last_byte;
    logic        out_of_range;
    logic        misaligned;
    logic        req_fault;
    logic        req_aligned;
    logic        req_split;

    assign active   = req_valid && !rst && (state == IDLE);
    assign req_size = access_size(req_funct3);
    assign f3_legal = req_write ? (req_funct3 inside {F3_SB, F3_SH, F3_SW})
                                : (req_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    // 33-bit sum so addresses near 2^32 cannot wrap back into range.
    assign last_byte    = {1'b0, req_addr} + {30'b0, req_size} - 33'd1;
    assign out_of_range = last_byte > 33'(MEM_BYTES - 1);
    assign misaligned   = ((req_size == 3'd2) && req_addr[0]) ||
                          ((req_size == 3'd4) && (req_addr[1:0] != 2'b00));
    assign req_fault    = active && (!f3_legal || out_of_range);
    assign req_aligned  = active && f3_legal && !out_of_range && !misaligned;
    assign req_split    = active && f3_legal && !out_of_range && misaligned;

    // One extender serves both paths: DONE extends the assembled bytes with
    // the latched funct3, otherwise the raw memory word with the live funct3.
    logic [2:0]  ext_funct3;
    logic [31:0] ext_in;
    logic [31:0] ext_out;

    assign ext_funct3 = (state == DONE) ? funct3_lat : req_funct3;
    assign ext_in     = (state == DONE) ? asm_data   : mem_read_data;

    lsu_load_ext u_ext (
        .funct3 (ext_funct3),
        .data   (ext_in),
        .ext    (ext_out)
    );

    always_comb begin
        stall          = 1'b0;
        fault          = 1'b0;
        rdata          = 32'b0;
        MemRead        = 1'b0;
        MemWrite       = 1'b0;
        mem_funct3     = 3'b000;
        mem_addr       = 32'b0;
        mem_write_data = 32'b0;
        case (state)
            IDLE: begin
                if (req_fault) begin
                    fault = 1'b1;
                end else if (req_aligned) begin
                    MemRead        = !req_write;
                    MemWrite       = req_write;
                    mem_funct3     = req_funct3;
                    mem_addr       = req_addr;
                    mem_write_data = req_wdata;
                    rdata          = req_write ? 32'b0 : ext_out;
                end else if (req_split) begin
                    // Byte 0 of the split goes out in the accept cycle.
                    stall          = 1'b1;
                    MemRead        = !req_write;
                    MemWrite       = req_write;
                    mem_funct3     = req_write ? F3_SB : F3_LBU;
                    mem_addr       = req_addr;
                    mem_write_data = {24'b0, req_wdata[7:0]};
                end
            end
            SPLIT: begin
                stall          = 1'b1;
                MemRead        = !write_lat;
                MemWrite       = write_lat;
                mem_funct3     = write_lat ? F3_SB : F3_LBU;
                mem_addr       = addr_lat + {30'b0, idx};
                mem_write_data = {24'b0, wdata_lat[{idx, 3'b000} +: 8]};
            end
            DONE: begin
                rdata = write_lat ? 32'b0 : ext_out;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= 2'd0;
            last_idx       <= 2'd0;
            addr_lat       <= 32'b0;
            wdata_lat      <= 32'b0;
            funct3_lat     <= 3'b000;
            write_lat      <= 1'b0;
            asm_data       <= 32'b0;
            misalign_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_split) begin
                        addr_lat   <= req_addr;
                        wdata_lat  <= req_wdata;
                        funct3_lat <= req_funct3;
                        write_lat  <= req_write;
                        last_idx   <= 2'(req_size - 3'd1);
                        asm_data   <= {24'b0, mem_read_data[7:0]};
                        idx        <= 2'd1;
                        state      <= SPLIT;
                    end
                end
                SPLIT: begin
                    asm_data[{idx, 3'b000} +: 8] <= mem_read_data[7:0];
                    if (idx == last_idx) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
                DONE: begin
                    if (misalign_count != {CNT_W{1'b1}}) begin
                        misalign_count <= misalign_count + 1'b1;
                    end
                    idx   <= 2'd0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_misalign_seq.sv
// Bench for lsu_misalign_seq: a byte-array data memory model, a table of
// requests with hand-derived results checked through a scoreboard queue,
// and directed sequences for split-store timing and mid-split reset.
module tb_lsu_misalign_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        stall;
    logic [31:0] rdata;
    logic        fault;
    logic [15:0] misalign_count;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_misalign_seq #(.MEM_BYTES(128), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .stall          (stall),
        .rdata          (rdata),
        .fault          (fault),
        .misalign_count (misalign_count),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite),
        .mem_funct3     (mem_funct3),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // ---------------- data memory model ----------------
    logic [7:0]  mem [0:127];
    logic        init_done = 1'b0;
    logic [6:0]  ma0, ma1, ma2, ma3;
    logic [31:0] raw;

    assign ma0 = mem_addr[6:0];
    assign ma1 = ma0 + 7'd1;
    assign ma2 = ma0 + 7'd2;
    assign ma3 = ma0 + 7'd3;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'(i);
            init_done <= 1'b1;
        end else if (MemWrite) begin
            mem[ma0] <= mem_write_data[7:0];
            if (mem_funct3[1:0] != 2'b00) mem[ma1] <= mem_write_data[15:8];
            if (mem_funct3[1:0] == 2'b10) begin
                mem[ma2] <= mem_write_data[23:16];
                mem[ma3] <= mem_write_data[31:24];
            end
        end
    end

    always_comb begin
        raw = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};
        case (mem_funct3)
            3'b000:  mem_read_data = {{24{raw[7]}}, raw[7:0]};
            3'b001:  mem_read_data = {{16{raw[15]}}, raw[15:0]};
            3'b100:  mem_read_data = {24'b0, raw[7:0]};
            3'b101:  mem_read_data = {16'b0, raw[15:0]};
            default: mem_read_data = raw;
        endcase
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        chk_rd;
        logic        exp_fault;
        int          exp_stall;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic void add(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rd, input logic chk,
                                input logic flt, input int st);
        vec_t v;
        v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_rd = rd; v.chk_rd = chk; v.exp_fault = flt; v.exp_stall = st;
        vecs.push_back(v);
    endfunction

    // Per-cycle record of the byte accesses issued while stalled.
    logic [31:0] seq_addr [0:7];
    logic [2:0]  seq_f3   [0:7];
    logic [1:0]  seq_rw   [0:7];

    // Presents a request at a negedge and holds it until stall drops.
    // Returns the outputs seen in the final (non-stalled) cycle.
    task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rd, output logic flt,
                           output int n, output logic [1:0] act, output logic [2:0] f3o,
                           output logic [31:0] ao);
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        #1;
        n = 0;
        while (stall && n < 8) begin
            seq_addr[n] = mem_addr;
            seq_f3[n]   = mem_funct3;
            seq_rw[n]   = {MemRead, MemWrite};
            n++;
            @(negedge clk);
            #1;
        end
        rd  = rdata;
        flt = fault;
        act = {MemRead, MemWrite};
        f3o = mem_funct3;
        ao  = mem_addr;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] rd, ao;
        logic        flt;
        logic [1:0]  act;
        logic [2:0]  f3o;
        int          n;
        vec_t        e;
        int          exp_cnt;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset stall", 32'(stall), 32'd0);
        check("reset fault", 32'(fault), 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset memctl", 32'({MemRead, MemWrite}), 32'd0);
        check("reset count", 32'(misalign_count), 32'd0);

        // ---- request table: wr, f3, addr, wdata, rdata, chk_rd, fault, stall cycles ----
        add(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, 0, 0);
        add(0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1, 0, 0);
        add(0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 1, 0, 0);
        add(0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 1, 0, 0);
        add(0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 1, 0, 0);
        add(0, 3'b101, 32'h10, 32'h0,        32'h0000BEEF, 1, 0, 0);
        add(1, 3'b010, 32'h11, 32'h44332211, 32'h0,        1, 0, 4);
        add(0, 3'b010, 32'h11, 32'h0,        32'h44332211, 1, 0, 4);
        add(0, 3'b010, 32'h10, 32'h0,        32'h332211EF, 1, 0, 0);
        add(0, 3'b001, 32'h11, 32'h0,        32'h00002211, 1, 0, 2);
        add(1, 3'b000, 32'h07, 32'hFFFFFF00, 32'h0,        0, 0, 0);
        add(1, 3'b000, 32'h08, 32'h12345680, 32'h0,        0, 0, 0);
        add(0, 3'b001, 32'h07, 32'h0,        32'hFFFF8000, 1, 0, 2);
        add(0, 3'b101, 32'h07, 32'h0,        32'h00008000, 1, 0, 2);
        add(0, 3'b010, 32'h7E, 32'h0,        32'h0,        1, 1, 0);
        add(0, 3'b010, 32'h7C, 32'h0,        32'h7F7E7D7C, 1, 0, 0);
        add(0, 3'b001, 32'h7F, 32'h0,        32'h0,        1, 1, 0);
        add(0, 3'b000, 32'h7F, 32'h0,        32'h0000007F, 1, 0, 0);
        add(0, 3'b010, 32'hFFFFFFFF, 32'h0,  32'h0,        1, 1, 0);
        add(0, 3'b010, 32'h80, 32'h0,        32'h0,        1, 1, 0);
        add(0, 3'b011, 32'h20, 32'h0,        32'h0,        1, 1, 0);
        add(1, 3'b100, 32'h20, 32'h55,       32'h0,        1, 1, 0);
        add(0, 3'b001, 32'h7D, 32'h0,        32'h00007E7D, 1, 0, 2);
        add(0, 3'b010, 32'h7B, 32'h0,        32'h7E7D7C7B, 1, 0, 4);
        add(0, 3'b010, 32'h7D, 32'h0,        32'h0,        1, 1, 0);

        exp_cnt = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            exp_q.push_back(vecs[i]);
            run_req(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, flt, n, act, f3o, ao);
            e = exp_q.pop_front();
            $display("txn %0d wr=%0d f3=%0d addr=%08h rdata=%08h fault=%0d stalls=%0d count=%0d",
                     i, e.wr, e.f3, e.addr, rd, flt, n, misalign_count);
            check($sformatf("t%0d fault", i), 32'(flt), 32'(e.exp_fault));
            check($sformatf("t%0d stalls", i), 32'(n), 32'(e.exp_stall));
            if (e.chk_rd) check($sformatf("t%0d rdata", i), rd, e.exp_rd);
            // Memory is driven in the final cycle only for aligned legal accesses.
            if (!e.exp_fault && e.exp_stall == 0) begin
                check($sformatf("t%0d memctl", i), 32'(act), 32'({!e.wr, e.wr}));
                check($sformatf("t%0d mem_funct3", i), 32'(f3o), 32'(e.f3));
                check($sformatf("t%0d mem_addr", i), ao, e.addr);
            end else begin
                check($sformatf("t%0d memctl", i), 32'(act), 32'd0);
            end
            for (int k = 0; k < n && k < e.exp_stall; k++) begin
                check($sformatf("t%0d byte%0d addr", i, k), seq_addr[k], e.addr + 32'(k));
                check($sformatf("t%0d byte%0d f3", i, k), 32'(seq_f3[k]), e.wr ? 32'd0 : 32'd4);
                check($sformatf("t%0d byte%0d rw", i, k), 32'(seq_rw[k]), 32'({!e.wr, e.wr}));
            end
            if (e.exp_stall > 0) exp_cnt++;
            check($sformatf("t%0d count", i), 32'(misalign_count), 32'(exp_cnt));
        end

        // ---- split sh 0x1234 at 0x03: one byte committed per issue cycle ----
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001; req_addr = 32'h03; req_wdata = 32'h00001234;
        #1;
        check("sh c1 stall", 32'(stall), 32'd1);
        check("sh c1 addr", mem_addr, 32'h03);
        check("sh c1 wbyte", 32'(mem_write_data[7:0]), 32'h34);
        @(negedge clk); #1;
        check("sh c2 mem3", 32'(mem[3]), 32'h34);
        check("sh c2 mem4", 32'(mem[4]), 32'h04);
        check("sh c2 stall", 32'(stall), 32'd1);
        check("sh c2 addr", mem_addr, 32'h04);
        @(negedge clk); #1;
        check("sh c3 mem4", 32'(mem[4]), 32'h12);
        check("sh c3 stall", 32'(stall), 32'd0);
        check("sh c3 memwrite", 32'(MemWrite), 32'd0);
        check("sh c3 rdata", rdata, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        exp_cnt++;
        check("sh count", 32'(misalign_count), 32'(exp_cnt));
        $display("txn sh addr=00000003 data=00001234 count=%0d", misalign_count);

        // ---- async reset in cycle 2 of a split sw at 0x01 ----
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h01; req_wdata = 32'hAABBCCDD;
        #1;
        check("rst c1 stall", 32'(stall), 32'd1);
        @(negedge clk); #1;
        check("rst c2 mem1", 32'(mem[1]), 32'hDD);
        rst = 1'b1;
        #1;
        check("rst stall", 32'(stall), 32'd0);
        check("rst memctl", 32'({MemRead, MemWrite}), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst mem1", 32'(mem[1]), 32'hDD);
        check("rst mem2", 32'(mem[2]), 32'h02);
        check("rst mem3", 32'(mem[3]), 32'h34);
        check("rst mem4", 32'(mem[4]), 32'h12);
        check("rst count", 32'(misalign_count), 32'd0);
        $display("txn reset-abort sw addr=00000001 mem1=%02h mem2=%02h", mem[1], mem[2]);

        // Sequencer is usable again: split lw over the partially written bytes.
        run_req(1'b0, 3'b010, 32'h01, 32'h0, rd, flt, n, act, f3o, ao);
        $display("txn post-reset lw addr=00000001 rdata=%08h stalls=%0d", rd, n);
        check("post lw rdata", rd, 32'h123402DD);
        check("post lw stalls", 32'(n), 32'd4);
        check("post lw count", 32'(misalign_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
